alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares the one registered 16-bit arithmetic/logic system between two requesters:
//  req 0 is the instruction datapath, req 1 is the PC/branch-address unit.
//  Uses round-robin arbitration over valid/ready request ports.
//  Drives the ALU's A/B/Imm/ALUsrc/ALUop inputs and routes the ALUout/AltB result,
//  one cycle later, to the requester that issued the op.
//  Each requester has a 1-entry response hold, so a stalled consumer never loses a result.
// PARAMETERS
//  WIDTH  16  datapath width (A, B, Imm, result)
//  OPW    3   ALU opcode width
// PORTS
//  clk          in   1          system clock; all state changes on posedge
//  rst_n        in   1          asynchronous, active-low reset
//  req_valid    in   2          bit i: requester i presents an op
//  req_ready    out  2          bit i: op i granted this cycle (one-hot or zero)
//  req_a        in   2*WIDTH    operand A, requester i in [i*WIDTH +: WIDTH]
//  req_b        in   2*WIDTH    operand B per requester
//  req_imm      in   2*WIDTH    immediate per requester
//  req_alusrc   in   2          ALUsrc per requester (selects Imm or B)
//  req_op       in   2*OPW      ALU opcode per requester
//  rsp_valid    out  2          bit i: result for requester i is presented
//  rsp_ready    in   2          bit i: requester i accepts its result this cycle
//  rsp_data     out  2*WIDTH    result per requester
//  rsp_altb     out  2          AltB flag per requester
//  alu_a/alu_b/alu_imm  out  WIDTH  to ALU A/B/Imm
//  alu_src      out  1          to ALUsrc
//  alu_op       out  OPW        to ALUop
//  alu_out      in   WIDTH      from ALUout (registered in the ALU, 1-cycle latency)
//  alu_altb     in   1          from AltB (registered in the ALU)
// BEHAVIOUR
//  Reset (async, rst_n=0): inflight[1:0]=0, hold_valid[1:0]=0, last_grant=1.
//   req_ready=0 and rsp_valid=0 while rst_n=0. Ops still in flight are discarded.
//  Eligibility: elig[i] = ~hold_valid[i] & ~(inflight[i] & ~rsp_ready[i]).
//  Grant: at most one per cycle, combinational; grant[i] requires req_valid[i] & elig[i].
//   - If only one requester qualifies, it wins.
//   - If both qualify, the one != last_grant wins.
//   - last_grant updates only on a grant.
//   - req_ready = grant.
//  ALU drive: in cycle t the granted requester's a/b/imm/alusrc/op go to alu_* combinationally.
//   With no grant, alu_* are driven to 0.
//  Latency: an op granted in cycle t sets inflight[i] at the t/t+1 edge.
//   Its result is on alu_out/alu_altb during t+1. Back-to-back grants give 1 op/cycle.
//  Response for requester i:
//   - rsp_valid[i] = hold_valid[i] | inflight[i].
//   - rsp_data/rsp_altb come from the hold register if hold_valid[i], else from alu_out/alu_altb.
//   - inflight[i] & ~rsp_ready[i] -> the hold captures alu_out/alu_altb and hold_valid[i] <= 1.
//   - hold_valid[i] & rsp_ready[i] -> hold_valid[i] <= 0.
//   - Results are delivered strictly in issue order per requester, with at most one outstanding.
//  alu_out is not reset; it is never forwarded unless inflight[i]=1.
//  A simultaneous grant to i and drain of hold i is impossible, because elig[i]=0 while hold_valid[i].
//  Combinational paths: rsp_ready -> req_ready, and req_* -> alu_*.
//  Requesters must hold req_* stable while req_valid=1 and req_ready=0.
// STRUCTURE
//  Package alu_arb_pkg holds:
//   - WIDTH and OPW defaults;
//   - REQ_DP=0 and REQ_BR=1 index constants;
//   - ALU opcode localparams shared with the control unit.
//  Sub-module alu_arb_rsp_slot is instantiated twice, one per requester.
//   It holds the inflight flag and the hold register/valid, and drives rsp_* and elig.
//  The top level holds the round-robin grant, last_grant and the alu_* mux.
// TESTING
//  1. Reset, then req0 a=5 b=3 op=ADD alusrc=1 -> req_ready=01 in the same cycle.
//     Next cycle rsp_valid=01 and rsp_data0=8.
//  2. Both valid every cycle, rsp_ready=11 -> grants 01,10,01,10...
//     Each result appears one cycle after its grant, on the correct port.
//  3. req1 op with rsp_ready1=0 for 3 cycles -> result is held stable, rsp_valid1=1, req_ready1=0.
//     Meanwhile req0 continues to be granted every cycle. rsp_ready1=1 -> drains, req1 eligible next cycle.
//  4. req0 a=2 b=9 SLT: rsp_altb0=1. Then req1 a=9 imm=2 alusrc=0: rsp_altb1=0.
//  5. rst_n deasserted mid-stream with inflight=11 and a full hold.
//     -> rsp_valid=00 and req_ready=00 immediately. After release, the first tie goes to req0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared widths, requester indices, ALU opcodes and the round-robin pick
package alu_arb_pkg;
    localparam int WIDTH  = 16;
    localparam int OPW    = 3;
    localparam int NREQ   = 2;
    localparam int REQ_DP = 0;
    localparam int REQ_BR = 1;
    localparam logic [OPW-1:0] ALU_ADD = 3'd0;
    localparam logic [OPW-1:0] ALU_SUB = 3'd1;
    localparam logic [OPW-1:0] ALU_AND = 3'd2;
    localparam logic [OPW-1:0] ALU_OR  = 3'd3;
    localparam logic [OPW-1:0] ALU_XOR = 3'd4;
    localparam logic [OPW-1:0] ALU_SLT = 3'd5;
    localparam logic [OPW-1:0] ALU_SHL = 3'd6;
    localparam logic [OPW-1:0] ALU_SHR = 3'd7;
    // On a tie the requester that did not win last time goes first
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] qual, input logic last);
        return (qual == 2'b11) ? (last ? 2'b01 : 2'b10) : qual;
    endfunction
endpackage

// File: rtl/alu_arb_rsp_slot.sv
// alu_arb_rsp_slot: per-requester in-flight flag and 1-entry result hold
module alu_arb_rsp_slot import alu_arb_pkg::*; #(
    parameter int W = alu_arb_pkg::WIDTH
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         issue_i,
    input  logic         rsp_ready_i,
    input  logic [W-1:0] alu_out_i,
    input  logic         alu_altb_i,
    output logic         rsp_valid_o,
    output logic [W-1:0] rsp_data_o,
    output logic         rsp_altb_o,
    output logic         elig_o
);
    logic         inflight_q, hold_valid_q, hold_altb_q;
    logic [W-1:0] hold_data_q;
    logic         capture, hold_valid_d;
    assign capture      = inflight_q & ~rsp_ready_i;
    assign hold_valid_d = hold_valid_q ? ~rsp_ready_i : capture;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_altb_q  <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            inflight_q   <= issue_i;
            hold_valid_q <= hold_valid_d;
            if (capture) begin
                hold_data_q <= alu_out_i;
                hold_altb_q <= alu_altb_i;
            end
        end
    end
    assign rsp_valid_o = hold_valid_q | inflight_q;
    assign rsp_data_o  = hold_valid_q ? hold_data_q : alu_out_i;
    assign rsp_altb_o  = hold_valid_q ? hold_altb_q : alu_altb_i;
    assign elig_o      = ~hold_valid_q & ~capture;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered ALU between the datapath
// and the branch-address unit, with results routed back one cycle later
module alu_arbiter import alu_arb_pkg::*; #(
    parameter int W = alu_arb_pkg::WIDTH,
    parameter int O = alu_arb_pkg::OPW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    input  logic [2*W-1:0] req_imm,
    input  logic [1:0]     req_alusrc,
    input  logic [2*O-1:0] req_op,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [2*W-1:0] rsp_data,
    output logic [1:0]     rsp_altb,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [W-1:0]   alu_imm,
    output logic           alu_src,
    output logic [O-1:0]   alu_op,
    input  logic [W-1:0]   alu_out,
    input  logic           alu_altb
);
    logic [1:0] elig, qual, grant;
    logic       last_q, last_d, sel;
    // Gating with rst_n keeps req_ready low for the whole reset assertion
    assign qual      = req_valid & elig & {2{rst_n}};
    assign grant     = rr_pick(qual, last_q);
    assign req_ready = grant;
    assign sel       = grant[REQ_BR];
    assign last_d    = |grant ? sel : last_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_imm = '0;
        alu_src = 1'b0;
        alu_op  = '0;
        if (|grant) begin
            alu_a   = sel ? req_a[REQ_BR*W +: W]   : req_a[REQ_DP*W +: W];
            alu_b   = sel ? req_b[REQ_BR*W +: W]   : req_b[REQ_DP*W +: W];
            alu_imm = sel ? req_imm[REQ_BR*W +: W] : req_imm[REQ_DP*W +: W];
            alu_src = sel ? req_alusrc[REQ_BR]     : req_alusrc[REQ_DP];
            alu_op  = sel ? req_op[REQ_BR*O +: O]  : req_op[REQ_DP*O +: O];
        end
    end
    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        alu_arb_rsp_slot #(.W(W)) u_slot (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .issue_i     (grant[i]),
            .rsp_ready_i (rsp_ready[i]),
            .alu_out_i   (alu_out),
            .alu_altb_i  (alu_altb),
            .rsp_valid_o (rsp_valid[i]),
            .rsp_data_o  (rsp_data[i*W +: W]),
            .rsp_altb_o  (rsp_altb[i]),
            .elig_o      (elig[i])
        );
    end
endmodule
